// File: rtl/basic_shield_guard.sv
// Over-current shield guard: debounces an async irq, reads the shield control
// register, writes back the tripped channel bits, then holds off before re-arming.
module basic_shield_guard #(
    parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
    parameter int unsigned DEBOUNCE  = 16,
    parameter int unsigned HOLDOFF   = 1024
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    output logic [31:0] avm_M_address,
    output logic        avm_M_read,
    output logic        avm_M_write,
    output logic [3:0]  avm_M_byteenable,
    output logic [31:0] avm_M_writedata,
    input  logic [31:0] avm_M_readdata,
    input  logic        avm_M_waitrequest,
    input  logic        inr_OC_irq,
    input  logic        coe_ARM_enable,
    input  logic        coe_TRIP_clear,
    output logic [1:0]  coe_TRIP_flags,
    output logic [7:0]  coe_TRIP_count,
    output logic        coe_BUSY
);

    typedef enum logic [2:0] {IDLE, RD, EVAL, WR, TRIPPED} state_t;

    localparam logic [15:0] DEB_LIMIT  = DEBOUNCE[15:0];
    localparam logic [15:0] HOLD_START = HOLDOFF[15:0];

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] dbnc_q, dbnc_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  rdata_q, rdata_d;
    logic [1:0]  flags_q, flags_d;
    logic [7:0]  count_q, count_d;
    logic [1:0]  oc;
    logic        unused_rd;

    // Only the PWREN lanes [25:24] and the over-current status [1:0] matter.
    assign unused_rd = ^{avm_M_readdata[31:26], avm_M_readdata[23:2]};
    assign oc        = rdata_q[1:0];

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            dbnc_q  <= '0;
            hold_q  <= '0;
            rdata_q <= '0;
            flags_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], inr_OC_irq};
            dbnc_q  <= dbnc_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dbnc_d  = '0;
        hold_d  = hold_q;
        rdata_d = rdata_q;
        flags_d = flags_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (sync_q[1] && coe_ARM_enable) begin
                    if (dbnc_q >= DEB_LIMIT) state_d = RD;
                    else                     dbnc_d  = dbnc_q + 16'd1;
                end
            end
            RD: begin
                if (!avm_M_waitrequest) begin
                    rdata_d = {avm_M_readdata[25:24], avm_M_readdata[1:0]};
                    state_d = coe_ARM_enable ? EVAL : IDLE;
                end
            end
            EVAL: begin
                if (!coe_ARM_enable || oc == 2'b00) state_d = IDLE;
                else                                state_d = WR;
            end
            WR: begin
                // An accepted write has switched channels off, so it is always recorded.
                if (!avm_M_waitrequest) begin
                    flags_d = flags_q | oc;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (coe_ARM_enable) begin
                        hold_d  = HOLD_START;
                        state_d = TRIPPED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TRIPPED: begin
                if (!coe_ARM_enable || hold_q <= 16'd1) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (coe_TRIP_clear) begin
            flags_d = '0;
            count_d = '0;
        end
    end

    always_comb begin
        avm_M_address    = CTRL_ADDR;
        avm_M_read       = (state_q == RD);
        avm_M_write      = (state_q == WR);
        avm_M_byteenable = 4'b0000;
        avm_M_writedata  = '0;
        if (state_q == RD) begin
            avm_M_byteenable = 4'b1111;
        end else if (state_q == WR) begin
            avm_M_byteenable = 4'b1000;
            avm_M_writedata  = {6'b0, rdata_q[3:2] | oc, 24'b0};
        end
    end

    assign coe_TRIP_flags = flags_q;
    assign coe_TRIP_count = count_q;
    assign coe_BUSY       = (state_q != IDLE);

endmodule

// File: doc/basic_shield_guard.md
BASIC_SHIELD_GUARD -- requirements
Module: basic_shield_guard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CTRL_ADDR, default 32'h0000_0000: byte address of the shield control/status register.
REQ-003 Parameter DEBOUNCE, default 16: consecutive synchronized-high cycles of inr_OC_irq required to trigger (range 1..65535).
REQ-004 Parameter HOLDOFF, default 1024: cycles spent in TRIPPED before re-arming (range 1..65535).
REQ-005 Ports SHALL be, in this order:
- csi_MCLK_clk, in, 1: clock.
- rsi_MRST_reset, in, 1: async active-high reset.
- avm_M_address, out, 32: always CTRL_ADDR.
- avm_M_read, out, 1: read request.
- avm_M_write, out, 1: write request.
- avm_M_byteenable, out, 4: byte lanes.
- avm_M_writedata, out, 32: write data.
- avm_M_readdata, in, 32: read data, valid in the cycle read is high and waitrequest is low.
- avm_M_waitrequest, in, 1: slave stall.
- inr_OC_irq, in, 1: over-current interrupt, asynchronous to the clock.
- coe_ARM_enable, in, 1: protection enabled.
- coe_TRIP_clear, in, 1: clears trip flags (level).
- coe_TRIP_flags, out, 2: sticky trip flags; bit 1 = channel B, bit 0 = channel A.
- coe_TRIP_count, out, 8: saturating trip counter.
- coe_BUSY, out, 1: high in any state other than IDLE.

Function
REQ-006 inr_OC_irq SHALL pass through a 2-flop synchronizer before any use.
REQ-007 The 16-bit debounce counter SHALL increment while the synchronized irq is high and coe_ARM_enable is high in IDLE; otherwise it SHALL be cleared.
REQ-008 The FSM states SHALL be IDLE, RD, EVAL, WR and TRIPPED.
REQ-009 IDLE -> RD SHALL occur when the debounce count reaches DEBOUNCE.
REQ-010 avm_M_read SHALL first assert exactly DEBOUNCE+2 rising edges after the first edge that samples inr_OC_irq high, provided irq stays high and ARM stays high throughout.
REQ-011 RD: read=1 and byteenable=4'b1111. Address and control SHALL be held stable while waitrequest=1; readdata SHALL be captured on the edge where waitrequest=0; then -> EVAL.
REQ-012 EVAL (1 cycle): oc = rd[1:0]. If oc == 0 -> IDLE (spurious; flags and count unchanged). Otherwise -> WR.
REQ-013 WR: write=1 and byteenable=4'b1000. writedata[25:24] = rd[25:24] | oc; all other writedata bits SHALL be 0. Signals SHALL be held while waitrequest=1. The channels already off SHALL stay off.
REQ-014 On write acceptance (waitrequest=0):
- flags |= oc;
- count increments, saturating at 8'hFF;
- load the holdoff counter with HOLDOFF;
- -> TRIPPED.
REQ-015 TRIPPED SHALL decrement the holdoff counter each cycle and -> IDLE at 0. The block SHALL never write PWREN back on.
REQ-016 read and write SHALL never be high in the same cycle. Both SHALL be 0 outside RD and WR.
REQ-017 When coe_ARM_enable falls during RD or WR, the block SHALL complete the pending transfer and then -> IDLE. EVAL -> IDLE and TRIPPED -> IDLE SHALL occur immediately.
REQ-018 coe_TRIP_clear=1 SHALL zero flags and count in any state. Clear SHALL take priority over a same-cycle flag set. The FSM SHALL be unaffected by clear.

Reset
REQ-019 Reset SHALL asynchronously force:
- state = IDLE;
- read = 0, write = 0, byteenable = 0, writedata = 0;
- flags = 0, count = 0, busy = 0;
- synchronizer, debounce and holdoff counters = 0.
REQ-020 Reset mid-transfer SHALL drop read/write immediately, with no completion.

Verification
REQ-021 DEBOUNCE=4, slave waitrequest=0. Irq high with readdata 32'h0000_0001 -> read at edge 6, EVAL, then write with writedata 32'h0100_0000 and byteenable 4'b1000; flags = 2'b01, count = 1.
REQ-022 Slave waitrequest=1 for 3 cycles in both RD and WR -> address, read/write, byteenable and writedata stable for all stalled cycles; exactly one read and one write complete.
REQ-023 Readdata 32'h0100_0002 (A already off, B over-current) -> writedata 32'h0300_0000; flags = 2'b10.
REQ-024 Irq pulse of DEBOUNCE-1 cycles -> no bus activity. Readdata 32'h0 -> read only, returns to IDLE, count = 0.
REQ-025 Reset asserted with waitrequest=1 in WR -> write=0 in the same cycle. ARM dropped in RD -> read completes, no write.
REQ-026 Run 256 trips -> count = 8'hFF. coe_TRIP_clear asserted during the write acceptance edge -> flags = 0, count = 0.
